// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester port identifiers and the read-tag record carried down the
// memory-latency pipeline.
package dmem_arbiter_pkg;

    // Arbiter states: free round-robin, or locked to port 0 / port 1.
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // Requester identifiers (processor is port 0, secondary master is port 1).
    localparam logic PORT_PROC = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    // Read tag: valid marks a read in flight, port names who receives it.
    typedef struct packed {
        logic valid;
        logic port;
    } rtag_t;

endpackage

// File: rtl/dmem_rtag_pipe.sv
// Read-tag delay line. A {valid, port} tag enters at the granting edge and
// appears at the output exactly MEM_LAT rising edges later, lined up with
// the data that the memory places on q for that access.
module dmem_rtag_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic  clock,
    input  logic  reset,
    input  rtag_t tag_in,
    output rtag_t tag_out
);

    rtag_t stage_q [MEM_LAT];
    rtag_t stage_d [MEM_LAT];

    // Shift one stage per clock; stage 0 takes the newly granted tag.
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < MEM_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipeline registers; reset drops every in-flight tag.
    always_ff @(posedge clock) begin
        for (int i = 0; i < MEM_LAT; i++) begin
            if (reset) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[MEM_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-port data memory between the processor
// (port 0) and a secondary master (port 1). One access is granted per clock
// by round-robin; a requester may lock the memory for a short atomic
// sequence, bounded by LOCK_MAX consecutive grants. Read data is routed back
// to the granting port MEM_LAT cycles after the grant.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wren,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    input  logic              m1_req,
    input  logic              m1_wren,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    arb_state_e state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       last_gnt_q, last_gnt_d;
    logic [7:0] hold_inc;
    rtag_t      tag_in;
    rtag_t      tag_out;

    // Grant selection: round-robin on ties in ARB, owner-only while locked,
    // nothing while reset is asserted.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                ARB: begin
                    if (m0_req && m1_req) begin
                        if (last_gnt_q == PORT_PROC) begin
                            m1_gnt = 1'b1;
                        end else begin
                            m0_gnt = 1'b1;
                        end
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
                LOCK0:   m0_gnt = m0_req;
                LOCK1:   m1_gnt = m1_req;
                default: ;
            endcase
        end
    end

    // Saturating increment of the locked-grant counter.
    assign hold_inc = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;

    // Next-state: enter a lock on a locked grant, leave it on unlock, on the
    // owner going idle, or when the hold limit is reached on a grant.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_gnt_d = last_gnt_q;
        if (m0_gnt) begin
            last_gnt_d = PORT_PROC;
        end else if (m1_gnt) begin
            last_gnt_d = PORT_AUX;
        end
        case (state_q)
            ARB: begin
                hold_cnt_d = 8'd0;
                if (m0_gnt && m0_lock) begin
                    state_d    = LOCK0;
                    hold_cnt_d = 8'd1;
                end else if (m1_gnt && m1_lock) begin
                    state_d    = LOCK1;
                    hold_cnt_d = 8'd1;
                end
            end
            LOCK0: begin
                if (!m0_gnt || !m0_lock || (hold_inc >= LOCK_MAX_C)) begin
                    state_d    = ARB;
                    hold_cnt_d = 8'd0;
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end
            LOCK1: begin
                if (!m1_gnt || !m1_lock || (hold_inc >= LOCK_MAX_C)) begin
                    state_d    = ARB;
                    hold_cnt_d = 8'd0;
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end
            default: begin
                state_d    = ARB;
                hold_cnt_d = 8'd0;
            end
        endcase
    end

    // Arbiter state registers; last_gnt starts at port 1 so port 0 wins the
    // first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ARB;
            hold_cnt_q <= 8'd0;
            last_gnt_q <= PORT_AUX;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Memory pin mux: granted port drives the memory, idle bus is all zero.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (m0_gnt) begin
            mem_address = m0_addr;
            mem_data    = m0_wdata;
            mem_wren    = m0_wren;
        end else if (m1_gnt) begin
            mem_address = m1_addr;
            mem_data    = m1_wdata;
            mem_wren    = m1_wren;
        end
    end

    // Only granted reads launch a valid tag; writes push an empty slot.
    always_comb begin
        tag_in.valid = (m0_gnt && !m0_wren) || (m1_gnt && !m1_wren);
        tag_in.port  = m1_gnt ? PORT_AUX : PORT_PROC;
    end

    dmem_rtag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_rtag_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Return path: mem_q goes to the tagged port only, the other sees zero.
    always_comb begin
        m0_rvalid = tag_out.valid && (tag_out.port == PORT_PROC);
        m1_rvalid = tag_out.valid && (tag_out.port == PORT_AUX);
        m0_rdata  = m0_rvalid ? mem_q : '0;
        m1_rdata  = m1_rvalid ? mem_q : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read latency of two cycles.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int MEM_LAT  = 2;
    localparam int LOCK_MAX = 8;

    logic              clock;
    logic              reset;
    logic              m0_req, m0_wren, m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m1_req, m1_wren, m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    int checks;
    int failures;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_LAT  (MEM_LAT),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .m0_req      (m0_req),
        .m0_wren     (m0_wren),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_lock     (m0_lock),
        .m1_req      (m1_req),
        .m1_wren     (m1_wren),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_lock     (m1_lock),
        .m0_gnt      (m0_gnt),
        .m1_gnt      (m1_gnt),
        .m0_rvalid   (m0_rvalid),
        .m1_rvalid   (m1_rvalid),
        .m0_rdata    (m0_rdata),
        .m1_rdata    (m1_rdata),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read-only memory contents: one marked word, the rest address-derived.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        return {8'hC0, 12'h000, a};
    endfunction

    // Memory model: q shows the addressed word MEM_LAT edges after the address.
    logic [MEM_LAT-1:0][DATA_W-1:0] rd_pipe;
    always @(posedge clock) begin
        rd_pipe[0] <= mem_word(mem_address);
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_q = rd_pipe[MEM_LAT-1];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_wren = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_wren = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        m0_req = 1; m1_req = 1; m0_addr = 12'h055;
        step();
        step();
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            failures++; $display("FAIL reset_gnt_forced got=%b exp=00", {m0_gnt, m1_gnt});
        end
        reset = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wren} !== 5'b0 ||
            mem_address !== '0 || m0_rdata !== '0 || m1_rdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b%b rv=%b%b wren=%b addr=%h rd0=%h rd1=%h exp all zero",
                     m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wren, mem_address, m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req = 1; m0_addr = 12'h010;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10 || mem_address !== 12'h010 || mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL read_grant got gnt=%b%b addr=%h wren=%b exp gnt=10 addr=010 wren=0",
                     m0_gnt, m1_gnt, mem_address, mem_wren);
        end
        step();
        m0_req = 0;
        #1;
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
            failures++; $display("FAIL read_early_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid});
        end
        step();
        #1;
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'hDEADBEEF || m1_rdata !== '0) begin
            failures++;
            $display("FAIL read_data got rv=%b%b rd0=%h rd1=%h exp rv=10 rd0=deadbeef rd1=0",
                     m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
        end
        step();
        #1;
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== '0) begin
            failures++;
            $display("FAIL read_one_shot got rv=%b%b rd0=%h exp rv=00 rd0=0", m0_rvalid, m1_rvalid, m0_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt, exp_rv;
        logic [DATA_W-1:0] exp_rd0, exp_rd1;
        do_reset();
        m0_addr = 12'h020;
        m1_addr = 12'h021;
        for (int i = 0; i < 9; i++) begin
            m0_req = (i < 6);
            m1_req = (i < 6);
            #1;
            if (i < 6) begin
                exp_gnt = (i % 2 == 0) ? 2'b10 : 2'b01;
                checks++;
                if ({m0_gnt, m1_gnt} !== exp_gnt) begin
                    failures++; $display("FAIL b2b_gnt cycle=%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, exp_gnt);
                end
            end
            if (i >= 2) begin
                if (i >= 8) begin
                    exp_rv = 2'b00; exp_rd0 = '0; exp_rd1 = '0;
                end else if ((i - 2) % 2 == 0) begin
                    exp_rv = 2'b10; exp_rd0 = 32'hC0000020; exp_rd1 = '0;
                end else begin
                    exp_rv = 2'b01; exp_rd0 = '0; exp_rd1 = 32'hC0000021;
                end
                checks++;
                if ({m0_rvalid, m1_rvalid} !== exp_rv || m0_rdata !== exp_rd0 || m1_rdata !== exp_rd1) begin
                    failures++;
                    $display("FAIL b2b_rdata cycle=%0d got rv=%b rd0=%h rd1=%h exp rv=%b rd0=%h rd1=%h",
                             i, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, exp_rv, exp_rd0, exp_rd1);
                end
            end
            step();
        end
    endtask

    task automatic test_write();
        do_reset();
        m1_req = 1; m1_wren = 1; m1_addr = 12'h0AB; m1_wdata = 32'h12345678;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_wren} !== 3'b011 || mem_address !== 12'h0AB || mem_data !== 32'h12345678) begin
            failures++;
            $display("FAIL write_bus got gnt=%b%b wren=%b addr=%h data=%h exp gnt=01 wren=1 addr=0ab data=12345678",
                     m0_gnt, m1_gnt, mem_wren, mem_address, mem_data);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (mem_wren !== 1'b0 || mem_address !== '0 || mem_data !== '0) begin
            failures++;
            $display("FAIL write_idle_bus got wren=%b addr=%h data=%h exp all zero", mem_wren, mem_address, mem_data);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
                failures++; $display("FAIL write_no_rvalid cycle=%0d got=%b exp=00", i, {m0_rvalid, m1_rvalid});
            end
            step();
        end
    endtask

    task automatic test_lock_max();
        logic [1:0] exp_gnt;
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 12'h030;
        m1_req = 1; m1_addr = 12'h031;
        for (int i = 1; i <= 12; i++) begin
            if (i == 11) m0_lock = 0;
            #1;
            if (i <= 8)       exp_gnt = 2'b10;
            else if (i == 9)  exp_gnt = 2'b01;
            else if (i <= 11) exp_gnt = 2'b10;
            else              exp_gnt = 2'b01;
            checks++;
            if ({m0_gnt, m1_gnt} !== exp_gnt) begin
                failures++; $display("FAIL lock_gnt cycle=%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, exp_gnt);
            end
            step();
        end
    endtask

    task automatic test_lock_drop();
        do_reset();
        m1_req = 1; m1_lock = 1; m1_addr = 12'h040;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            failures++; $display("FAIL drop_lock_gnt got=%b exp=01", {m0_gnt, m1_gnt});
        end
        step();
        m1_req = 0; m1_lock = 0;
        m0_req = 1; m0_addr = 12'h041;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b00 || mem_address !== '0) begin
            failures++;
            $display("FAIL drop_dead_cycle got gnt=%b addr=%h exp gnt=00 addr=0", {m0_gnt, m1_gnt}, mem_address);
        end
        step();
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10 || mem_address !== 12'h041) begin
            failures++;
            $display("FAIL drop_next_gnt got gnt=%b addr=%h exp gnt=10 addr=041", {m0_gnt, m1_gnt}, mem_address);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        m0_req = 1; m0_addr = 12'h010;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++; $display("FAIL midrst_grant got=%b exp=10", {m0_gnt, m1_gnt});
        end
        step();
        m0_req = 0;
        m1_req = 1; m1_addr = 12'h050;
        reset = 1'b1;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_in_reset got gnt=%b rv=%b exp 00 00", {m0_gnt, m1_gnt}, {m0_rvalid, m1_rvalid});
        end
        step();
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wren} !== 5'b0 || mem_address !== '0 ||
                mem_data !== '0 || m0_rdata !== '0 || m1_rdata !== '0) begin
                failures++;
                $display("FAIL midrst_after cycle=%0d got gnt=%b rv=%b wren=%b addr=%h rd0=%h exp all zero",
                         i, {m0_gnt, m1_gnt}, {m0_rvalid, m1_rvalid}, mem_wren, mem_address, m0_rdata);
            end
            step();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write();
        test_lock_max();
        test_lock_drop();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory (dmem) between the processor and a second requester (loader/debug/DMA master). It sits between the requesters and the dmem address/data/wren/q pins, picks one access per clock by round-robin, honours short locked sequences bounded by a hold limit, and returns read data to the granted requester with its tag after the fixed memory latency.

## Interface
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, dmem data width
- MEM_LAT, 1, cycles from address presented to valid mem_q (1..4)
- LOCK_MAX, 8, max consecutive grants to a locked requester before forced release (2..255)

- clock  in  1  master clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- m0_req / m1_req  in  1  access request (m0 = processor, m1 = secondary)
- m0_wren / m1_wren  in  1  1 = write, 0 = read; meaningful with req
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_lock / m1_lock  in  1  keep grant on next cycle (atomic sequence)
- m0_gnt / m1_gnt  out  1  access accepted this cycle (combinational from req and state)
- m0_rvalid / m1_rvalid  out  1  read data valid
- m0_rdata / m1_rdata  out  DATA_W  read data (mem_q passthrough, qualified by rvalid)
- mem_address  out  ADDR_W  to dmem address
- mem_data  out  DATA_W  to dmem data
- mem_wren  out  1  to dmem write enable
- mem_q  in  DATA_W  from dmem q

## Operation
- FSM states: ARB, LOCK0, LOCK1. Reset → ARB.
- ARB: one req → grant it. Both req → grant port != last_gnt; last_gnt resets to 1 (port 0 wins first tie).
- Granted port drives mem_address/mem_data/mem_wren; no grant → mem_address=0, mem_data=0, mem_wren=0.
- At most one gnt high per cycle. gnt without req never asserted.
- Grant with lock=1 → next state LOCKx, hold_cnt=1. LOCKx: only port x may be granted; other req waits.
- LOCKx exit to ARB when: port x granted with lock=0; or port x req=0 (lock dropped, no grant that cycle); or hold_cnt reaches LOCK_MAX on a grant (forced release, last_gnt=x so other port wins next tie).
- hold_cnt increments per locked grant, saturates; cleared on entry to ARB.
- last_gnt updates on every grant.
- Reads: tag {valid, port} enters MEM_LAT-deep shift register at grant; at output, tagged port's rvalid=1 for one cycle, rdata = mem_q. Writes insert valid=0.
- Untagged port's rdata = 0.
- Back-to-back reads from either port, one per cycle, full throughput; no bubbles between ARB grants.

## Timing
- Grant latency: 0 cycles (gnt same cycle as req when selected).
- Read data: rvalid exactly MEM_LAT rising edges after the granting edge.
- Write: committed at the granting edge; requester may change addr/data next cycle.
- Reset values: all gnt 0, all rvalid 0, rdata 0, mem_wren 0, mem_address 0, state ARB, hold_cnt 0, last_gnt 1, tag pipeline cleared.
- Reset mid-read: in-flight tags dropped; no rvalid after reset edge.
- Reset asserted same cycle as req: gnt forced 0.
- Simultaneous lock release and other req: other port granted the cycle after release, not the same cycle.

## Structure
- Shared package: state encoding (ARB/LOCK0/LOCK1), port-id constants PORT_PROC=0, PORT_AUX=1.
- Sub-module dmem_rtag_pipe: MEM_LAT-deep {valid, port} shift register with sync reset.
- Processor-side stall = m0_req & ~m0_gnt, wired in the skeleton, not in this block.

## Test plan
- Reset then m0 read addr 0x010, mem returns 0xDEADBEEF → m0_gnt same cycle, m0_rvalid=1 with 0xDEADBEEF exactly MEM_LAT cycles later, m1_rvalid stays 0.
- Both req every cycle, reads, 6 cycles → grants alternate 0,1,0,1,0,1; rvalid tags follow same order.
- m1 write 0x0AB=0x12345678 while m0 idle → mem_wren=1, mem_address=0x0AB, mem_data=0x12345678 one cycle; no rvalid.
- m0 lock held with continuous req, m1 req, LOCK_MAX=8 → m0 granted 8 consecutive cycles, m1 granted cycle 9.
- m1 lock asserted, then m1 req drops while m0 req → one dead cycle (no gnt), m0 granted next cycle.
- Reset asserted one cycle after read grant with MEM_LAT=2 → no rvalid on either port; all outputs 0 next cycle.
